// File: rtl/pcu_pkg.sv
// Shared types and instruction field helpers for the parametrised control unit.
// Fields are extracted from a zero-extended copy of the instruction word.
package pcu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXEC,
      WB
   } state_t;

   typedef enum logic [1:0] {
      OP_ALU,
      OP_MV,
      OP_MVI,
      OP_RSVD
   } opcode_t;

   // Widest instruction the field helpers handle.
   localparam int FIELD_W = 64;

   function automatic logic [FIELD_W-1:0] field_get(
      input logic [FIELD_W-1:0] word,
      input int                 lsb,
      input int                 width
   );
      field_get = (word >> lsb) & ((FIELD_W'(1) << width) - FIELD_W'(1));
   endfunction

   function automatic int rx_lsb(input int instr_w, input int reg_aw);
      rx_lsb = instr_w - reg_aw;
   endfunction

   function automatic int ry_lsb(input int instr_w, input int reg_aw);
      ry_lsb = instr_w - 2 * reg_aw;
   endfunction

   function automatic int op_lsb(input int instr_w, input int reg_aw);
      op_lsb = instr_w - 2 * reg_aw - 2;
   endfunction

endpackage

// File: rtl/pcu_onehot.sv
// Binary index plus enable to N-bit one-hot decoder; all bits low when disabled.
module pcu_onehot #(
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic [AW-1:0] idx,
   input  logic          en,
   output logic [N-1:0]  onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign onehot[gi] = en && (idx == AW'(gi));
      end
   endgenerate

endmodule

// File: rtl/param_control_unit.sv
// Multi-cycle control FSM for the register-file datapath: latches an instruction on run
// and sequences ALU, move and immediate-load operations with Moore-decoded controls.
module param_control_unit
   import pcu_pkg::*;
#(
   parameter  int NUM_REGS  = 8,
   parameter  int INSTR_W   = 16,
   parameter  int ALU_SEL_W = 4,
   localparam int REG_AW    = $clog2(NUM_REGS),
   localparam int MUX_SEL_W = $clog2(NUM_REGS + 2)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_W-1:0]   instruction,
   input  logic                 run,
   output logic [MUX_SEL_W-1:0] mux_sel,
   output logic [NUM_REGS-1:0]  reg_en,
   output logic                 en_a,
   output logic                 en_g,
   output logic [ALU_SEL_W-1:0] alu_sel,
   output logic                 alu_mode,
   output logic                 busy,
   output logic                 done,
   output logic                 illegal
);

   state_t               state_reg, state_next;
   logic [INSTR_W-1:0]   ir_reg, ir_next;
   logic [FIELD_W-1:0]   ir_ext;
   logic [REG_AW-1:0]    rx, ry;
   logic [1:0]           op_bits;
   opcode_t              op;
   logic [ALU_SEL_W-1:0] ir_alu_sel;
   logic                 ir_alu_mode;
   logic                 wr_en;

   assign ir_ext      = FIELD_W'(ir_reg);
   assign rx          = REG_AW'(field_get(ir_ext, rx_lsb(INSTR_W, REG_AW), REG_AW));
   assign ry          = REG_AW'(field_get(ir_ext, ry_lsb(INSTR_W, REG_AW), REG_AW));
   assign op_bits     = 2'(field_get(ir_ext, op_lsb(INSTR_W, REG_AW), 2));
   assign op          = opcode_t'(op_bits);
   assign ir_alu_sel  = ALU_SEL_W'(field_get(ir_ext, 1, ALU_SEL_W));
   assign ir_alu_mode = ir_reg[0];

   // The instruction register only follows the input on an accepted run.
   assign ir_next = (state_reg == IDLE && run) ? instruction : ir_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      mux_sel    = '0;
      wr_en      = 1'b0;
      en_a       = 1'b0;
      en_g       = 1'b0;
      alu_sel    = '0;
      alu_mode   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      illegal    = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (run) state_next = LOAD;
         end
         LOAD: begin
            case (op)
               OP_ALU: begin
                  mux_sel    = MUX_SEL_W'(rx);
                  en_a       = 1'b1;
                  state_next = EXEC;
               end
               OP_MV: begin
                  mux_sel    = MUX_SEL_W'(ry);
                  wr_en      = 1'b1;
                  done       = 1'b1;
                  state_next = IDLE;
               end
               OP_MVI: begin
                  mux_sel    = MUX_SEL_W'(NUM_REGS);
                  wr_en      = 1'b1;
                  done       = 1'b1;
                  state_next = IDLE;
               end
               default: begin
                  illegal    = 1'b1;
                  done       = 1'b1;
                  state_next = IDLE;
               end
            endcase
         end
         EXEC: begin
            mux_sel    = MUX_SEL_W'(ry);
            alu_sel    = ir_alu_sel;
            alu_mode   = ir_alu_mode;
            en_g       = 1'b1;
            state_next = WB;
         end
         WB: begin
            mux_sel    = MUX_SEL_W'(NUM_REGS + 1);
            wr_en      = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   pcu_onehot #(
      .N  (NUM_REGS),
      .AW (REG_AW)
   ) u_reg_en_dec (
      .idx    (rx),
      .en     (wr_en),
      .onehot (reg_en)
   );

endmodule

// File: tb/tb_param_control_unit.sv
// Table-driven, scoreboard-checked bench for param_control_unit at default parameters.
module tb_param_control_unit;

   typedef struct packed {
      logic [3:0] mux;
      logic [7:0] reg_en;
      logic       en_a;
      logic       en_g;
      logic [3:0] alu_sel;
      logic       alu_mode;
      logic       busy;
      logic       done;
      logic       illegal;
   } out_t;

   typedef struct {
      logic [15:0] instr;
      int          len;
      out_t        c1;
      out_t        c2;
      out_t        c3;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instruction;
   logic        run;
   logic [3:0]  mux_sel;
   logic [7:0]  reg_en;
   logic        en_a, en_g, alu_mode, busy, done, illegal;
   logic [3:0]  alu_sel;
   out_t        dut_out;

   int   tests = 0;
   int   failures = 0;
   out_t sb[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   param_control_unit dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .run         (run),
      .mux_sel     (mux_sel),
      .reg_en      (reg_en),
      .en_a        (en_a),
      .en_g        (en_g),
      .alu_sel     (alu_sel),
      .alu_mode    (alu_mode),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal)
   );

   assign dut_out = {mux_sel, reg_en, en_a, en_g, alu_sel, alu_mode, busy, done, illegal};

   function automatic out_t mk(input logic [3:0] mux, input logic [7:0] ren, input logic a,
                               input logic g, input logic [3:0] sel, input logic mode,
                               input logic bsy, input logic dn, input logic ill);
      mk = {mux, ren, a, g, sel, mode, bsy, dn, ill};
   endfunction

   // Advance one clock, then compare the outputs against the oldest expectation.
   task automatic step(input string name);
      out_t exp;
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty, got=%h", name, dut_out);
      end else begin
         exp = sb.pop_front();
         if (dut_out !== exp) begin
            failures++;
            $display("FAIL %s: got=%h required=%h (mux=%0d reg_en=%h a=%b g=%b sel=%0d mode=%b busy=%b done=%b ill=%b)",
                     name, dut_out, exp, mux_sel, reg_en, en_a, en_g, alu_sel, alu_mode,
                     busy, done, illegal);
         end
      end
   endtask

   initial begin
      out_t z;
      z = '0;

      vecs[0] = '{16'h2806, 3, mk(1, 8'h00, 1, 0, 0, 0, 1, 0, 0),
                               mk(2, 8'h00, 0, 1, 3, 0, 1, 0, 0),
                               mk(9, 8'h02, 0, 0, 0, 0, 1, 1, 0)};
      vecs[1] = '{16'hA200, 1, mk(8, 8'h20, 0, 0, 0, 0, 1, 1, 0), z, z};
      vecs[2] = '{16'h7900, 1, mk(6, 8'h08, 0, 0, 0, 0, 1, 1, 0), z, z};
      vecs[3] = '{16'h0300, 1, mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 1), z, z};
      vecs[4] = '{16'hFC15, 3, mk(7, 8'h00, 1, 0, 0, 0, 1, 0, 0),
                               mk(7, 8'h00, 0, 1, 4'hA, 1, 1, 0, 0),
                               mk(9, 8'h80, 0, 0, 0, 0, 1, 1, 0)};
      vecs[5] = '{16'h01FF, 1, mk(0, 8'h01, 0, 0, 0, 0, 1, 1, 0), z, z};
      vecs[6] = '{16'hE2FF, 1, mk(8, 8'h80, 0, 0, 0, 0, 1, 1, 0), z, z};

      // Reset state
      reset = 1'b1;
      run = 1'b0;
      instruction = 16'h0000;
      sb.push_back(z); step("reset_cycle0");
      sb.push_back(z); step("reset_cycle1");
      reset = 1'b0;
      sb.push_back(z); step("idle_after_reset");

      // Table of single instructions, each followed by one idle cycle
      foreach (vecs[i]) begin
         $display("[TB] vector %0d instr=%h len=%0d", i, vecs[i].instr, vecs[i].len);
         instruction = vecs[i].instr;
         run = 1'b1;
         sb.push_back(vecs[i].c1);
         if (vecs[i].len > 1) sb.push_back(vecs[i].c2);
         if (vecs[i].len > 2) sb.push_back(vecs[i].c3);
         sb.push_back(z);
         step($sformatf("v%0d_c1", i));
         run = 1'b0;
         instruction = 16'h0300;
         for (int c = 2; c <= vecs[i].len; c++) step($sformatf("v%0d_c%0d", i, c));
         step($sformatf("v%0d_idle", i));
      end

      // Reset mid-ALU while in EXEC aborts without any write-back
      $display("[TB] sequence reset_mid_alu");
      instruction = 16'h2806;
      run = 1'b1;
      sb.push_back(vecs[0].c1);
      sb.push_back(vecs[0].c2);
      step("rst_load");
      run = 1'b0;
      step("rst_exec");
      reset = 1'b1;
      sb.push_back(z); step("rst_abort0");
      sb.push_back(z); step("rst_abort1");
      reset = 1'b0;
      sb.push_back(z); step("rst_no_wb");
      sb.push_back(z); step("rst_still_idle");

      // run held high with instruction changed mid-op
      $display("[TB] sequence run_held_toggle");
      instruction = 16'h2806;
      run = 1'b1;
      sb.push_back(vecs[0].c1);
      sb.push_back(vecs[0].c2);
      sb.push_back(vecs[0].c3);
      sb.push_back(z);
      sb.push_back(vecs[1].c1);
      sb.push_back(z);
      step("held_load");
      instruction = 16'hA200;
      step("held_exec");
      step("held_wb");
      step("held_accept_idle");
      step("held_mvi");
      run = 1'b0;
      step("held_final_idle");

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
